// File: rtl/level_display_hold.sv
// level_display_hold
// Display stage behind the output-level meter. Samples the meter's BCD
// digits and sign once per refresh period. In peak mode it holds the
// largest value for a fixed number of refresh ticks and then releases it.
// The result drives four active-low seven-segment digits, with the sign on
// hex3 and leading-zero blanking on the hundreds and tens digits.
//
// Timing: on the tick cycle the inputs are captured into disp on the next
// edge. The segment registers follow one edge later, so the hex outputs show
// a sample two edges after its tick cycle. held follows the FSM state and
// changes on the same edge as disp.

module level_display_hold #(
  parameter int REFRESH = 4800,
  parameter int HOLD    = 20
) (
  input  logic       clk_48,
  input  logic       reset_n,
  input  logic [3:0] num2,
  input  logic [3:0] num1,
  input  logic [3:0] num0,
  input  logic       neg,
  input  logic       peak_en,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       held
);

  localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD);

  localparam logic [0:0] ST_TRACK = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Active-low gfedcba pattern for one BCD digit. Only 0..9 reach this,
  // because digits are clamped before they are stored.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Saturate a raw BCD nibble to 9 so illegal codes still display sensibly.
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // ---------------------------------------------------------------------
  // Refresh tick
  // ---------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : (cnt_q + CW'(1));

  // Free-running refresh counter, 0..REFRESH-1.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------
  // Input normalisation
  // ---------------------------------------------------------------------
  // The BCD form is kept alongside the signed value. The segment stage then
  // needs no binary-to-decimal conversion. The signed value is used only for
  // the peak comparison.
  logic [3:0]         samp_d2, samp_d1, samp_d0;
  logic [10:0]        samp_mag;
  logic               samp_neg;
  logic signed [10:0] samp_val;

  assign samp_d2  = clamp9(num2);
  assign samp_d1  = clamp9(num1);
  assign samp_d0  = clamp9(num0);
  assign samp_mag = 11'(samp_d2) * 11'd100 + 11'(samp_d1) * 11'd10 + 11'(samp_d0);
  // A negative zero shows as +0, so no stray minus sign appears.
  assign samp_neg = neg && (samp_mag != 11'd0);
  assign samp_val = samp_neg ? -$signed(samp_mag) : $signed(samp_mag);

  // ---------------------------------------------------------------------
  // Track / hold FSM
  // ---------------------------------------------------------------------
  logic [0:0]         state_q, state_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic               disp_load;
  logic signed [10:0] disp_val_q;
  logic               disp_neg_q;
  logic [3:0]         disp_d2_q, disp_d1_q, disp_d0_q;
  logic               held_q;

  // Next-state and display-load decision, evaluated only on a tick.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    disp_load  = 1'b0;
    if (tick) begin
      if (!peak_en) begin
        // Live tracking: follow every sample and drop any hold.
        disp_load  = 1'b1;
        state_d    = ST_TRACK;
        hold_cnt_d = '0;
      end else if (state_q == ST_TRACK) begin
        // Entering peak mode: the current sample becomes the first peak.
        disp_load  = 1'b1;
        state_d    = ST_HOLD;
        hold_cnt_d = HOLD_LD;
      end else if (samp_val > disp_val_q) begin
        // A new higher peak restarts the hold window. An equal sample does
        // not restart it.
        disp_load  = 1'b1;
        hold_cnt_d = HOLD_LD;
      end else if (hold_cnt_q > HW'(1)) begin
        hold_cnt_d = hold_cnt_q - HW'(1);
      end else begin
        // Hold window expired: release to the current sample and start a
        // new window. A count of zero cannot occur in HOLD, but it is
        // treated as expiry so the FSM can never get stuck.
        disp_load  = 1'b1;
        hold_cnt_d = HOLD_LD;
      end
    end
  end

  // FSM state, hold counter and held flag registers.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_TRACK;
      hold_cnt_q <= '0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      held_q     <= (state_d == ST_HOLD);
    end
  end

  // Displayed value. The signed form and the BCD form are loaded together.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      disp_val_q <= '0;
      disp_neg_q <= 1'b0;
      disp_d2_q  <= 4'd0;
      disp_d1_q  <= 4'd0;
      disp_d0_q  <= 4'd0;
    end else if (disp_load) begin
      disp_val_q <= samp_val;
      disp_neg_q <= samp_neg;
      disp_d2_q  <= samp_d2;
      disp_d1_q  <= samp_d1;
      disp_d0_q  <= samp_d0;
    end
  end

  // ---------------------------------------------------------------------
  // Segment stage
  // ---------------------------------------------------------------------
  logic [6:0] hex3_q, hex2_q, hex1_q, hex0_q;

  // Registered segment encode. The sign stays on hex3, and leading zeros in
  // the hundreds and tens positions are blanked.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      hex3_q <= SEG_BLANK;
      hex2_q <= SEG_BLANK;
      hex1_q <= SEG_BLANK;
      hex0_q <= 7'h40;
    end else begin
      hex3_q <= disp_neg_q ? SEG_MINUS : SEG_BLANK;
      hex2_q <= (disp_d2_q == 4'd0) ? SEG_BLANK : seg7(disp_d2_q);
      hex1_q <= ((disp_d2_q == 4'd0) && (disp_d1_q == 4'd0)) ? SEG_BLANK : seg7(disp_d1_q);
      hex0_q <= seg7(disp_d0_q);
    end
  end

  assign hex3 = hex3_q;
  assign hex2 = hex2_q;
  assign hex1 = hex1_q;
  assign hex0 = hex0_q;
  assign held = held_q;

endmodule

// File: tb/tb_level_display_hold.sv
// Bench for level_display_hold with REFRESH=4 and HOLD=3.
// A behavioural model holds the displayed value as a plain integer. It
// derives the expected segments arithmetically and pushes one expected
// vector per clock edge into exp_q. The checker compares that vector against
// the DUT on every falling edge. Directed steps add literal expectations.

module tb_level_display_hold;

  localparam int REFRESH = 4;
  localparam int HOLD    = 3;

  // ---------------- clock / reset ----------------
  logic       clk_48  = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] num2 = 4'd0, num1 = 4'd1, num0 = 4'd2;
  logic       neg = 1'b0, peak_en = 1'b0;
  logic [6:0] hex3, hex2, hex1, hex0;
  logic       held;

  always #5 clk_48 = ~clk_48;

  level_display_hold #(.REFRESH(REFRESH), .HOLD(HOLD)) dut (
    .clk_48 (clk_48),
    .reset_n(reset_n),
    .num2   (num2),
    .num1   (num1),
    .num0   (num0),
    .neg    (neg),
    .peak_en(peak_en),
    .hex3   (hex3),
    .hex2   (hex2),
    .hex1   (hex1),
    .hex0   (hex0),
    .held   (held)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  // Expected vector layout: {hex3, hex2, hex1, hex0, held}.
  logic [28:0] exp_q[$];
  localparam logic [28:0] RESET_VEC = {7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b0};

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model state: the displayed value, hold mode, the number of ticks left in
  // the hold window, the position in the refresh period and a tick count.
  int m_disp  = 0;
  bit m_hold  = 1'b0;
  int m_left  = 0;
  int m_cnt   = 0;
  int m_ticks = 0;

  // Convert the current input pins into the signed display value.
  function automatic int sample_value();
    int d2, d1, d0, mag;
    d2  = (num2 > 9) ? 9 : int'(num2);
    d1  = (num1 > 9) ? 9 : int'(num1);
    d0  = (num0 > 9) ? 9 : int'(num0);
    mag = 100 * d2 + 10 * d1 + d0;
    return neg ? -mag : mag;
  endfunction

  // Segment picture of an integer value, with held left at 0.
  function automatic logic [28:0] show(int v);
    int mag, h, t, u;
    logic [6:0] s3, s2, s1, s0;
    mag = (v < 0) ? -v : v;
    h   = mag / 100;
    t   = (mag / 10) % 10;
    u   = mag % 10;
    s3  = (v < 0) ? 7'h3F : 7'h7F;
    s2  = (h == 0) ? 7'h7F : seg_tab[h];
    s1  = (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
    s0  = seg_tab[u];
    return {s3, s2, s1, s0, 1'b0};
  endfunction

  // Behavioural model, advanced on each clock edge or asynchronous reset.
  initial begin
    forever begin
      @(posedge clk_48 or negedge reset_n);
      if (!reset_n) begin
        m_disp = 0;
        m_hold = 1'b0;
        m_left = 0;
        m_cnt  = 0;
        exp_q.delete();
        exp_q.push_back(RESET_VEC);
      end else begin
        logic [28:0] e;
        int s;
        // The segments at this edge show the value held before the edge.
        e = show(m_disp);
        if (m_cnt == REFRESH - 1) begin
          s = sample_value();
          m_ticks++;
          if (!peak_en) begin
            m_disp = s; m_hold = 1'b0; m_left = 0;
          end else if (!m_hold) begin
            m_disp = s; m_hold = 1'b1; m_left = HOLD;
          end else if (s > m_disp) begin
            m_disp = s; m_left = HOLD;
          end else if (m_left > 1) begin
            m_left = m_left - 1;
          end else begin
            m_disp = s; m_left = HOLD;
          end
        end
        e[0] = m_hold;
        exp_q.push_back(e);
        m_cnt = (m_cnt + 1) % REFRESH;
      end
    end
  end

  task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input logic [28:0] e);
    cmp({tag, ".hex3"}, hex3, e[28:22]);
    cmp({tag, ".hex2"}, hex2, e[21:15]);
    cmp({tag, ".hex1"}, hex1, e[14:8]);
    cmp({tag, ".hex0"}, hex0, e[7:1]);
    cmp({tag, ".held"}, {6'd0, held}, {6'd0, e[0]});
  endtask

  // Per-cycle compare against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk_48);
      if (exp_q.size() > 0) cmp_all("model", exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                        input logic n, input logic p);
    @(negedge clk_48);
    #1;
    num2 = d2; num1 = d1; num0 = d0; neg = n; peak_en = p;
  endtask

  // Wait until the next tick's sample is visible on the hex outputs.
  task automatic wait_visible();
    int t0, n;
    t0 = m_ticks;
    n  = 0;
    while (m_ticks == t0 && n < 3 * REFRESH) begin
      @(negedge clk_48);
      n++;
    end
    if (m_ticks == t0) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout actual=no_tick expected=tick_within_%0d", 3 * REFRESH);
    end
    @(negedge clk_48);
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (m_cnt != v && n < 3 * REFRESH) begin
      @(negedge clk_48);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state, then the first update 4 cycles plus 2 edges after release.
    repeat (2) @(negedge clk_48);
    cmp_all("rst", RESET_VEC);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clk_48);
    cmp_all("first_pre", RESET_VEC);
    @(negedge clk_48);
    cmp_all("first_012", {7'h7F, 7'h7F, 7'h79, 7'h24, 1'b0});

    // Live mode and leading-zero blanking.
    set_in(4'd3, 4'd0, 4'd5, 1'b1, 1'b0); wait_visible();
    cmp_all("live_m305", {7'h3F, 7'h30, 7'h40, 7'h12, 1'b0});
    set_in(4'd0, 4'd0, 4'd0, 1'b1, 1'b0); wait_visible();
    cmp_all("live_negzero", {7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b0});

    // Peak hold and release.
    set_in(4'd0, 4'd5, 4'd0, 1'b0, 1'b1); wait_visible();
    cmp_all("peak_50", {7'h7F, 7'h7F, 7'h12, 7'h40, 1'b1});
    set_in(4'd0, 4'd2, 4'd0, 1'b0, 1'b1); wait_visible();
    cmp_all("hold_50_a", {7'h7F, 7'h7F, 7'h12, 7'h40, 1'b1});
    wait_visible();
    cmp_all("hold_50_b", {7'h7F, 7'h7F, 7'h12, 7'h40, 1'b1});
    wait_visible();
    cmp_all("release_20", {7'h7F, 7'h7F, 7'h24, 7'h40, 1'b1});

    // Re-arm with a signed compare.
    set_in(4'd0, 4'd1, 4'd0, 1'b1, 1'b0); wait_visible();
    cmp_all("live_m010", {7'h3F, 7'h7F, 7'h79, 7'h40, 1'b0});
    set_in(4'd0, 4'd1, 4'd0, 1'b1, 1'b1); wait_visible();
    cmp_all("peak_m010", {7'h3F, 7'h7F, 7'h79, 7'h40, 1'b1});
    set_in(4'd0, 4'd0, 4'd5, 1'b1, 1'b1); wait_visible();
    cmp_all("rearm_m005", {7'h3F, 7'h7F, 7'h7F, 7'h12, 1'b1});
    set_in(4'd0, 4'd0, 4'd8, 1'b1, 1'b1); wait_visible();
    cmp_all("hold_m005_a", {7'h3F, 7'h7F, 7'h7F, 7'h12, 1'b1});
    wait_visible();
    cmp_all("hold_m005_b", {7'h3F, 7'h7F, 7'h7F, 7'h12, 1'b1});
    wait_visible();
    cmp_all("release_m008", {7'h3F, 7'h7F, 7'h7F, 7'h00, 1'b1});

    // Mode switch out of hold.
    set_in(4'd0, 4'd4, 4'd2, 1'b0, 1'b0); wait_visible();
    cmp_all("mode_42", {7'h7F, 7'h7F, 7'h19, 7'h24, 1'b0});

    // Clamping of illegal BCD digits.
    set_in(4'd0, 4'hC, 4'd3, 1'b0, 1'b0); wait_visible();
    cmp_all("clamp_093", {7'h7F, 7'h7F, 7'h10, 7'h30, 1'b0});
    set_in(4'hF, 4'hF, 4'hF, 1'b0, 1'b0); wait_visible();
    cmp_all("clamp_999", {7'h7F, 7'h10, 7'h10, 7'h10, 1'b0});

    // Glitch the inputs and peak_en between ticks; the display must not change.
    wait_cnt(0);
    #1; num2 = 4'd7; num1 = 4'd7; num0 = 4'd7; neg = 1'b1; peak_en = 1'b1;
    @(negedge clk_48);
    #1; num2 = 4'hF; num1 = 4'hF; num0 = 4'hF; neg = 1'b0; peak_en = 1'b0;
    repeat (2 * REFRESH) @(negedge clk_48);
    cmp_all("glitch_999", {7'h7F, 7'h10, 7'h10, 7'h10, 1'b0});

    // Reset mid-hold and the restart timing.
    set_in(4'd1, 4'd2, 4'd3, 1'b0, 1'b1); wait_visible();
    cmp_all("peak_123", {7'h7F, 7'h79, 7'h24, 7'h30, 1'b1});
    wait_cnt(2);
    #1 reset_n = 1'b0;
    #1 cmp_all("async_rst", RESET_VEC);
    repeat (2) @(negedge clk_48);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clk_48);
    cmp_all("rst_tick_held", {7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b1});
    @(negedge clk_48);
    cmp_all("rst_peak_123", {7'h7F, 7'h79, 7'h24, 7'h30, 1'b1});

    // Randomised phase, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_48);
      #1;
      if (i == 300) reset_n = 1'b0;
      else          reset_n = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        num2    = 4'($urandom_range(0, 15));
        num1    = 4'($urandom_range(0, 15));
        num0    = 4'($urandom_range(0, 15));
        neg     = 1'($urandom_range(0, 1));
        peak_en = ($urandom_range(0, 4) != 0);
      end
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk_48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
